// File: rtl/core_pkg.sv
// Shared types for the instruction fetch slice: bus width, FSM encoding and buffer payload.
// FETCH_MISALIGN_EXC_EN adds a misaligned-target flag to each buffered entry.
package core_pkg;

  localparam int DATA_WIDTH = 64;

  // Encoding of addi x0, x0, 0, handed to decode in place of a misaligned fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

`ifdef FETCH_MISALIGN_EXC_EN
  typedef struct packed {
    logic        misaligned;
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;
`else
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;
`endif

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the AXI read port and decode: power-of-two ring of
// {data, pc} entries with push, pop and a flush that may carry one fresh push.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (flush || !full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      cnt    <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy lives in cnt
  // and the consumer masks the head while empty, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch unit: one-outstanding AXI-lite read FSM feeding a small buffer.
// FETCH_MISALIGN_EXC_EN adds instr_misaligned and a halting misaligned-redirect path.
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [31:0]           instr_data,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
`ifdef FETCH_MISALIGN_EXC_EN
  output logic                  instr_misaligned,
`endif
  input  logic                  instr_ready
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   ar_addr;
  logic          drop, drop_next;
  logic [31:0]   tgt_pc;
  logic          mis_redirect;
  logic          halted_next;
  logic          resp_push;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic          can_issue;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef FETCH_MISALIGN_EXC_EN
  logic halted;

  assign tgt_pc       = redirect_pc;
  assign mis_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign halted_next  = redirect_valid ? mis_redirect : halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else        halted <= halted_next;
  end
`else
  logic unused_redirect_lsbs;

  assign tgt_pc               = {redirect_pc[31:2], 2'b00};
  assign mis_redirect         = 1'b0;
  assign halted_next          = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  if (DATA_WIDTH > 32) begin : g_wide_rdata
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^RDATA[DATA_WIDTH-1:32];
  end

  // A redirect wins over the response push; it may instead carry the exception entry.
  assign resp_push = (state == DATA) && RVALID && !drop && !redirect_valid;
  assign fifo_push = redirect_valid ? mis_redirect : resp_push;
  assign fifo_pop  = instr_valid && instr_ready;

  always_comb begin
    push_entry = '0;
    if (redirect_valid) begin
      push_entry.data = NOP_INSTR;
      push_entry.pc   = tgt_pc;
`ifdef FETCH_MISALIGN_EXC_EN
      push_entry.misaligned = 1'b1;
`endif
    end else begin
      push_entry.data = RDATA[31:0];
      push_entry.pc   = pc;
    end
  end

  // Occupancy once this edge's push/pop/flush land; a new AR reserves one slot of it.
  always_comb begin
    if (redirect_valid) count_after = CW'(mis_redirect);
    else                count_after = fifo_count + CW'(resp_push) - CW'(fifo_pop);
  end

  assign can_issue = !halted_next && (count_after < DEPTH_C);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    if (redirect_valid) pc_next = tgt_pc;
    case (state)
      IDLE: if (can_issue) state_next = ADDR;
      ADDR: begin
        if (redirect_valid) drop_next = 1'b1;
        if (ARREADY) state_next = DATA;
      end
      DATA: begin
        if (RVALID) begin
          drop_next  = 1'b0;
          if (resp_push) pc_next = pc + 32'd4;
          // Skipping IDLE when a slot is free keeps the issue interval at two cycles.
          state_next = can_issue ? ADDR : IDLE;
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      drop  <= drop_next;
    end
  end

  // The address is captured on entry to ADDR so a redirect cannot disturb a pending AR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_addr <= '0;
    end else if ((state_next == ADDR) && (state != ADDR)) begin
      ar_addr <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (head),
    .full       (unused_fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign ARADDR      = ar_addr;
  assign ARVALID     = (state == ADDR);
  assign RREADY      = (state == DATA);
  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_empty ? '0 : head.data;
  assign instr_pc    = fifo_empty ? '0 : head.pc;
`ifdef FETCH_MISALIGN_EXC_EN
  assign instr_misaligned = fifo_empty ? 1'b0 : head.misaligned;
`endif

endmodule
